// File: rtl/fifo_async_if.sv
// Producer/consumer handshake bundle for fifo_async.
// The FIFO attaches through the slave modport; the requester side uses master.
interface fifo_async_if #(
    parameter int data_width = 8
);
    logic                  write;
    logic [data_width-1:0] write_data;
    logic                  write_full;
    logic                  read;
    logic [data_width-1:0] read_data;
    logic                  read_empty;

    modport master (
        output write,
        output write_data,
        output read,
        input  write_full,
        input  read_data,
        input  read_empty
    );

    modport slave (
        input  write,
        input  write_data,
        input  read,
        output write_full,
        output read_data,
        output read_empty
    );
endinterface

// File: rtl/fifo_async.sv
// Single-clock FIFO, 2^addr_width x data_width, asynchronous active-high reset.
// Optional occupancy output fill_count is enabled by defining FIFO_ASYNC_COUNT_EN.
module fifo_async #(
    parameter int data_width = 8,
    parameter int addr_width = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FIFO_ASYNC_COUNT_EN
    output logic [addr_width:0] fill_count,
`endif
    fifo_async_if.slave       bus
);

    localparam int depth = 1 << addr_width;
    localparam logic [addr_width:0] ptr_one = {{addr_width{1'b0}}, 1'b1};

    logic [data_width-1:0] mem_q [depth];

    logic [addr_width:0]   wptr_q;
    logic [addr_width:0]   wptr_d;
    logic [addr_width:0]   rptr_q;
    logic [addr_width:0]   rptr_d;
    logic [data_width-1:0] rdata_q;
    logic [data_width-1:0] rdata_d;

    logic empty_s;
    logic full_s;
    logic wr_acc_s;
    logic rd_acc_s;

    // Wrap bit distinguishes full (same index, different lap) from empty.
    assign empty_s = (wptr_q == rptr_q);
    assign full_s  = (wptr_q[addr_width-1:0] == rptr_q[addr_width-1:0]) &&
                     (wptr_q[addr_width] != rptr_q[addr_width]);

    assign bus.read_empty = empty_s;
    assign bus.write_full = full_s;
    assign bus.read_data  = rdata_q;

    // Request acceptance and next-state pointers / read word
    always_comb begin
        rd_acc_s = 1'b0;
        wr_acc_s = 1'b0;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        rdata_d  = rdata_q;
        if (!rst) begin
            rd_acc_s = bus.read && !empty_s;
            // A read in the same cycle frees the slot, so a write at full still lands.
            wr_acc_s = bus.write && (!full_s || rd_acc_s);
        end else begin
            rd_acc_s = 1'b0;
            wr_acc_s = 1'b0;
        end
        if (wr_acc_s) begin
            wptr_d = wptr_q + ptr_one;
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_acc_s) begin
            rptr_d  = rptr_q + ptr_one;
            rdata_d = mem_q[rptr_q[addr_width-1:0]];
        end else begin
            rptr_d  = rptr_q;
            rdata_d = rdata_q;
        end
    end

    // Storage array; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wptr_q[addr_width-1:0]] <= bus.write_data;
        end
    end

    // Pointer and output-word registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef FIFO_ASYNC_COUNT_EN
    logic [addr_width:0] fill_q;
    logic [addr_width:0] fill_d;

    // Modulo difference of the next pointers keeps the count in step with them.
    always_comb begin
        fill_d = wptr_d - rptr_d;
    end

    // Occupancy register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign fill_count = fill_q;
`endif

endmodule

// File: tb/tb_fifo_async.sv
// Directed plus randomized bench for fifo_async, checked against a queue-based model.
module tb_fifo_async;

    logic clk;
    logic rst;
`ifdef FIFO_ASYNC_COUNT_EN
    logic [4:0] fill_count;
`endif

    fifo_async_if #(.data_width(8)) bus ();

    fifo_async #(.data_width(8), .addr_width(4)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef FIFO_ASYNC_COUNT_EN
        .fill_count (fill_count),
`endif
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    logic [7:0] model_q[$];
    logic [7:0] exp_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".read_data"}, {24'd0, bus.read_data}, {24'd0, exp_rdata});
        check({tag, ".read_empty"}, {31'd0, bus.read_empty}, (model_q.size() == 0) ? 32'd1 : 32'd0);
        check({tag, ".write_full"}, {31'd0, bus.write_full}, (model_q.size() == 16) ? 32'd1 : 32'd0);
`ifdef FIFO_ASYNC_COUNT_EN
        check({tag, ".fill_count"}, {27'd0, fill_count}, model_q.size());
`endif
    endtask

    // One clock with the given request; the model applies the FIFO rules afterwards.
    task automatic cyc(input string tag, input logic w, input logic [7:0] wd, input logic r);
        bit rd_ok;
        bit wr_ok;
        bus.write      = w;
        bus.write_data = wd;
        bus.read       = r;
        @(posedge clk);
        #1;
        rd_ok = r && (model_q.size() > 0);
        wr_ok = w && ((model_q.size() < 16) || rd_ok);
        if (rd_ok) exp_rdata = model_q.pop_front();
        if (wr_ok) model_q.push_back(wd);
        bus.write = 1'b0;
        bus.read  = 1'b0;
        check_all(tag);
    endtask

    // Mid-cycle reset pulse that never overlaps a rising edge.
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        exp_rdata = 8'h00;
        check_all(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        exp_rdata      = 8'h00;
        rst            = 1'b0;
        bus.write      = 1'b0;
        bus.write_data = 8'h00;
        bus.read       = 1'b0;

        // Reset with no clock edge involved
        #2;
        rst = 1'b1;
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic order: 10 writes, idle, 10 reads, one extra read
        for (int i = 1; i <= 10; i++) cyc("basic_wr", 1'b1, 8'(i), 1'b0);
        cyc("basic_idle", 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cyc("basic_rd", 1'b0, 8'h00, 1'b1);
            check("basic_rd_const", {24'd0, bus.read_data}, i);
        end
        check("basic_empty", {31'd0, bus.read_empty}, 32'd1);
        cyc("basic_rd11", 1'b0, 8'h00, 1'b1);
        check("basic_hold", {24'd0, bus.read_data}, 32'h0A);

        // Fill to full, overflow attempt, simultaneous access at full
        for (int i = 1; i <= 16; i++) cyc("full_wr", 1'b1, 8'(i), 1'b0);
        check("full_flag", {31'd0, bus.write_full}, 32'd1);
        cyc("overflow", 1'b1, 8'h11, 1'b0);
        cyc("full_simul", 1'b1, 8'h55, 1'b1);
        check("full_simul_data", {24'd0, bus.read_data}, 32'h01);
        check("full_simul_flag", {31'd0, bus.write_full}, 32'd1);
        for (int i = 0; i < 16; i++) cyc("full_drain", 1'b0, 8'h00, 1'b1);
        check("full_last", {24'd0, bus.read_data}, 32'h55);

        // Simultaneous access at empty: write only, no fall-through
        cyc("empty_simul", 1'b1, 8'h77, 1'b1);
        check("empty_simul_hold", {24'd0, bus.read_data}, 32'h55);
        cyc("empty_next", 1'b0, 8'h00, 1'b1);
        check("empty_next_data", {24'd0, bus.read_data}, 32'h77);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) cyc("mid_wr", 1'b1, 8'(8'hA0 + i), 1'b0);
        pulse_reset("mid_reset");
        cyc("mid_rd", 1'b0, 8'h00, 1'b1);
        check("mid_rd_zero", {24'd0, bus.read_data}, 32'h00);

        // Wrap-around from pointer 0 across index 15 -> 0
        for (int i = 0; i < 12; i++) cyc("wrap_wr1", 1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 12; i++) cyc("wrap_rd1", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) cyc("wrap_wr2", 1'b1, 8'(8'h21 + i), 1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc("wrap_rd2", 1'b0, 8'h00, 1'b1);
            check("wrap_rd2_const", {24'd0, bus.read_data}, 32'h21 + i);
        end

        // Randomized traffic with phases biased toward filling and draining
        for (int blk = 0; blk < 8; blk++) begin
            int wp;
            wp = (blk % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 100; i++) begin
                cyc("random",
                    ($urandom_range(99) < wp) ? 1'b1 : 1'b0,
                    8'($urandom),
                    ($urandom_range(99) < (100 - wp)) ? 1'b1 : 1'b0);
            end
            if (blk == 5) pulse_reset("random_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
